// File: rtl/keypad_lock_pkg.sv
// Shared types and constants for the keypad code-entry lock.
// Contents:
//   state_t  : controller FSM states; the encoding is visible on the mode output
//   beep_t   : buzzer pattern requests
//   KEY_*    : keypad codes for the non-digit keys
//   is_digit : true for key codes 0..9
package keypad_lock_pkg;

    typedef enum logic [2:0] {
        ENTRY   = 3'd0,
        CHECK   = 3'd1,
        OPEN    = 3'd2,
        SET     = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SHORT  = 2'd1,
        DOUBLE = 2'd2
    } beep_t;

    localparam logic [3:0] KEY_ENTER = 4'd10;
    localparam logic [3:0] KEY_BACK  = 4'd11;
    localparam logic [3:0] KEY_CLR   = 4'd12;
    localparam logic [3:0] KEY_SET   = 4'd13;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_lock_ctrl_key_event.sv
// Turns the debounced one-hot keypad vector into single key events.
// An event is a cycle with exactly one key bit set while the previous cycle
// had no key bit set; held keys, releases and multi-hot vectors give nothing.
// The event is registered, so it appears one cycle after detection.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   key_onehot : debounced keypad, bit i = key value i
//   key_valid  : one-cycle event strobe
//   key_code   : binary key value, meaningful while key_valid is high
module keypad_key_event (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] key_onehot,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    logic [15:0] prev_q;
    logic        one_hot;
    logic [3:0]  enc;

    always_comb begin
        // Clearing the lowest set bit leaves zero only for a single set bit.
        one_hot = (key_onehot != 16'd0) &&
                  ((key_onehot & (key_onehot - 16'd1)) == 16'd0);
        enc = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (key_onehot[i]) enc = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= 16'd0;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
        end else begin
            prev_q    <= key_onehot;
            key_valid <= one_hot && (prev_q == 16'd0);
            key_code  <= enc;
        end
    end

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Code-entry lock controller: digit editing, code check with a try limit,
// timed lockout, user code change while unlocked, patterned buzzer.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   key_onehot   : debounced one-hot keypad
//   entry        : BCD digits typed so far, newest in the LS nibble
//   entry_len    : number of digits held
//   tries_left   : remaining attempts before lockout
//   mode         : current FSM state encoding (state_t)
//   unlocked     : high in OPEN and SET
//   lockout      : high in LOCKOUT
//   buzzer       : buzzer drive
//   code_changed : one-cycle pulse when a new code is stored
// Handshake: key events are single-cycle strobes from keypad_key_event; the
// FSM consumes a strobe in the cycle it is present, there is no back-pressure.
module keypad_lock_ctrl
    import keypad_lock_pkg::*;
#(
    parameter int                  DIGITS       = 3,
    parameter int                  MAX_TRIES    = 3,
    parameter int                  LOCKOUT_CYC  = 500000000,
    parameter int                  BEEP_CYC     = 5000000,
    parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 12'h123
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         key_onehot,
    output logic [4*DIGITS-1:0] entry,
    output logic [3:0]          entry_len,
    output logic [3:0]          tries_left,
    output logic [2:0]          mode,
    output logic                unlocked,
    output logic                lockout,
    output logic                buzzer,
    output logic                code_changed
);

    localparam int         W          = 4 * DIGITS;
    localparam int         LW         = $clog2(LOCKOUT_CYC > 1 ? LOCKOUT_CYC : 2);
    localparam int         BW         = $clog2(BEEP_CYC > 1 ? BEEP_CYC : 2);
    localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);
    localparam logic [3:0] DIG_LEN    = 4'(DIGITS);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYC - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYC - 1);

    logic       key_valid;
    logic [3:0] key_code;

    keypad_key_event u_key_event (
        .clk        (clk),
        .rst        (rst),
        .key_onehot (key_onehot),
        .key_valid  (key_valid),
        .key_code   (key_code)
    );

    state_t        state_q, state_d;
    logic [W-1:0]  entry_q, entry_d, code_q, code_d, dig_ext;
    logic [3:0]    len_q, len_d, tries_q, tries_d;
    logic          match_q, match_d, cc_q, cc_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    beep_t         beep_req, beep_pat_q;
    logic [1:0]    beep_phase_q;
    logic [BW-1:0] beep_cnt_q;

    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        len_d      = len_q;
        tries_d    = tries_q;
        code_d     = code_q;
        match_d    = match_q;
        cc_d       = 1'b0;
        lock_cnt_d = '0;
        beep_req   = NONE;
        dig_ext    = W'(key_code);

        case (state_q)
            ENTRY, SET: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        if (len_q < DIG_LEN) begin
                            entry_d = (entry_q << 4) | dig_ext;
                            len_d   = len_q + 4'd1;
                        end else begin
                            beep_req = SHORT;
                        end
                    end else if (key_code == KEY_BACK) begin
                        if (len_q != 4'd0) begin
                            entry_d = entry_q >> 4;
                            len_d   = len_q - 4'd1;
                        end
                    end else if (key_code == KEY_CLR) begin
                        // In SET an empty-buffer clear backs out without change.
                        if (state_q == SET && len_q == 4'd0) begin
                            state_d = OPEN;
                        end else begin
                            entry_d = '0;
                            len_d   = 4'd0;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        if (len_q != DIG_LEN) begin
                            beep_req = SHORT;
                        end else if (state_q == SET) begin
                            code_d   = entry_q;
                            cc_d     = 1'b1;
                            beep_req = SHORT;
                            state_d  = OPEN;
                        end else begin
                            // entry clears on the way into CHECK, so the
                            // comparison result is captured here.
                            match_d = (entry_q == code_q);
                            state_d = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (match_q) begin
                    state_d  = OPEN;
                    tries_d  = TRIES_INIT;
                    beep_req = SHORT;
                end else begin
                    tries_d  = (tries_q != 4'd0) ? tries_q - 4'd1 : 4'd0;
                    beep_req = DOUBLE;
                    state_d  = (tries_q <= 4'd1) ? LOCKOUT : ENTRY;
                end
            end
            OPEN: begin
                if (key_valid) begin
                    if (key_code == KEY_CLR)      state_d = ENTRY;
                    else if (key_code == KEY_SET) state_d = SET;
                end
            end
            LOCKOUT: begin
                if (lock_cnt_q == LOCK_LAST) begin
                    state_d = ENTRY;
                    tries_d = TRIES_INIT;
                end else begin
                    lock_cnt_d = lock_cnt_q + LW'(1);
                end
            end
            default: state_d = ENTRY;
        endcase

        if (state_d != state_q) begin
            entry_d = '0;
            len_d   = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ENTRY;
            entry_q    <= '0;
            len_q      <= 4'd0;
            tries_q    <= TRIES_INIT;
            code_q     <= DEFAULT_CODE;
            match_q    <= 1'b0;
            cc_q       <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            len_q      <= len_d;
            tries_q    <= tries_d;
            code_q     <= code_d;
            match_q    <= match_d;
            cc_q       <= cc_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Beep sequencer: phase 0 high, phase 1 low, phase 2 high, each BEEP_CYC
    // long. SHORT ends after phase 0. A new request restarts from phase 0;
    // entering LOCKOUT drops any pattern since the buzzer is held high there.
    always_ff @(posedge clk) begin
        if (rst || state_d == LOCKOUT) begin
            beep_pat_q   <= NONE;
            beep_phase_q <= 2'd0;
            beep_cnt_q   <= '0;
        end else if (beep_req != NONE) begin
            beep_pat_q   <= beep_req;
            beep_phase_q <= 2'd0;
            beep_cnt_q   <= '0;
        end else if (beep_pat_q != NONE) begin
            if (beep_cnt_q == BEEP_LAST) begin
                beep_cnt_q <= '0;
                if (beep_pat_q == SHORT || beep_phase_q == 2'd2) beep_pat_q <= NONE;
                else beep_phase_q <= beep_phase_q + 2'd1;
            end else begin
                beep_cnt_q <= beep_cnt_q + BW'(1);
            end
        end
    end

    assign entry        = entry_q;
    assign entry_len    = len_q;
    assign tries_left   = tries_q;
    assign mode         = state_q;
    assign unlocked     = (state_q == OPEN) || (state_q == SET);
    assign lockout      = (state_q == LOCKOUT);
    assign buzzer       = lockout || (beep_pat_q != NONE && beep_phase_q != 2'd1);
    assign code_changed = cc_q;

endmodule
